mem_wb_skid_buffer: RTL
=======================

Name: mem_wb_skid_buffer

Overview:
- Parametrised successor to the fixed-width MEM/WB pipeline register.
- Carries read data, ALU result, destination register index and WB control from the MEM stage to the WB stage.
- Adds a valid/ready handshake with a 2-entry skid so WB back-pressure never creates a combinational ready path upstream.
- Adds flush, bubble masking of WB control, and a saturating stall counter.

Parameters:
DATA_W, 32, width of read-data and ALU-result fields
REG_W, 5, width of destination register index
WB_W, 2, width of WB control field
MASK_WB_ON_BUBBLE, 1, when 1 the out_wb output is forced to 0 whenever out_valid=0
CNT_W, 16, width of stall counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
flush  input  1  discard all held entries and the incoming beat
in_valid  input  1  MEM stage presents a beat
in_ready  output  1  buffer can accept a beat this cycle
in_rdata  input  DATA_W  memory read data
in_alu  input  DATA_W  ALU result
in_mux5  input  REG_W  destination register index
in_wb  input  WB_W  WB control (RegWrite, MemtoReg)
out_valid  output  1  beat presented to WB stage
out_ready  input  1  WB stage consumes beat
out_rdata  output  DATA_W  held read data
out_alu  output  DATA_W  held ALU result
out_mux5  output  REG_W  held destination index
out_wb  output  WB_W  held WB control, masked per MASK_WB_ON_BUBBLE
stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Storage is two entries:
  - main: drives the out_* ports, with flag main_v.
  - skid: with flag skid_v.
- out_valid = main_v.
- in_ready = !skid_v, purely from a register, with no combinational path from out_ready.
- Accept occurs when in_valid && in_ready. Deliver occurs when out_valid && out_ready.
- All updates happen on the rising clk edge. Priority order is rst > flush > normal.
- rst=1:
  - main_v=0 and skid_v=0.
  - All data fields in both entries and stall_cnt are 0.
  - in_ready reads 1 from the first cycle after reset.
  - Reset mid-stream drops all entries; no beat is delivered after it.
- flush=1 (rst=0):
  - main_v=0 and skid_v=0.
  - The incoming beat is discarded even if in_valid=1.
  - Data fields may keep stale values.
  - stall_cnt is unchanged.
- Normal operation, main entry:
  - main empty, or main delivering with skid empty: main loads the accepted beat if there is one; otherwise main_v=0.
  - main delivering with skid full: main <= skid and skid_v=0. No accept occurs that cycle because in_ready=0.
  - main full, not delivering, skid empty, accept: the beat goes to skid and skid_v=1.
  - main full, not delivering, skid full: hold. in_ready=0.
- Latency and throughput:
  - Latency in_valid to out_valid is 1 cycle.
  - Sustained throughput is 1 beat/cycle while out_ready=1.
  - Order is strictly FIFO.
- Hold stability: while out_valid=1 and out_ready=0, all out_* must stay constant.
- Bubble masking: with MASK_WB_ON_BUBBLE=1 and out_valid=0, out_wb=0. This guarantees no register-file write from a bubble. Other out_* fields are unmasked.
- stall_cnt:
  - Increments by 1 each cycle where out_valid && !out_ready.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Only rst clears it.
- No data transformation: fields are pass-through, bit-exact.

Test Plan:
- Reset then stream: rst 2 cycles, then in_valid=1 for 4 cycles with in_alu=1,2,3,4 and out_ready=1 -> out_valid rises 1 cycle after the first accept, out_alu=1,2,3,4 on consecutive cycles, in_ready stays 1, stall_cnt=0.
- Back-pressure skid: main holds alu=0xA, out_ready=0, in_valid=1 with alu=0xB -> skid captures 0xB, in_ready=0 next cycle, out_alu stays 0xA. Release out_ready -> 0xA then 0xB delivered in order, in_ready returns to 1 after the skid drains, stall_cnt equals the number of stalled cycles.
- Flush with both entries full plus in_valid=1 -> next cycle out_valid=0, in_ready=1, out_wb=2'b00. The incoming beat never appears at the output.
- Simultaneous: flush=1 and rst=1 with entries full -> all fields and stall_cnt=0. Then flush alone does not clear stall_cnt.
- Saturation: CNT_W=3, out_valid=1, out_ready=0 for 10 cycles -> stall_cnt reaches 7 and holds at 7.
- Bubble masking: in_wb=2'b11 accepted then delivered with no new input -> out_wb=2'b11 while valid, 2'b00 once out_valid=0. With MASK_WB_ON_BUBBLE=0, out_wb stays 2'b11.

Source files
------------

// File: rtl/mem_wb_skid_buffer.sv
// mem_wb_skid_buffer
//   MEM/WB pipeline register with a valid/ready handshake and a 2-entry skid.
//   The buffer carries read data, ALU result, destination index and WB control
//   from MEM to WB. in_ready comes only from a register, so WB back-pressure
//   never forms a combinational path back into MEM.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears flags, data and stall_cnt)
//   flush      drops both held entries and the incoming beat
//   in_valid   / in_ready    upstream handshake
//   in_rdata, in_alu, in_mux5, in_wb   upstream beat fields
//   out_valid  / out_ready   downstream handshake
//   out_rdata, out_alu, out_mux5, out_wb   main-entry fields (out_wb optionally
//                                          masked while out_valid=0)
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
module mem_wb_skid_buffer #(
  parameter int unsigned DATA_W            = 32,
  parameter int unsigned REG_W             = 5,
  parameter int unsigned WB_W              = 2,
  parameter bit          MASK_WB_ON_BUBBLE = 1'b1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_rdata,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [REG_W-1:0]  in_mux5,
  input  logic [WB_W-1:0]   in_wb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic [DATA_W-1:0] out_alu,
  output logic [REG_W-1:0]  out_mux5,
  output logic [WB_W-1:0]   out_wb,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  mux5;
    logic [WB_W-1:0]   wb;
  } entry_t;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  entry_t in_beat;
  logic   accept;
  logic   deliver;

  assign in_beat = '{rdata: in_rdata, alu: in_alu, mux5: in_mux5, wb: in_wb};
  assign in_ready = ~skid_v_q;
  assign accept   = in_valid & in_ready;
  assign deliver  = main_v_q & out_ready;

  always_comb begin
    main_d      = main_q;
    skid_d      = skid_q;
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      // Data fields are left stale; only the flags matter after a flush.
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      if (main_v_q && !out_ready && (stall_cnt_q != CntMax)) begin
        stall_cnt_d = stall_cnt_q + CntOne;
      end

      if (!main_v_q || (deliver && !skid_v_q)) begin
        // Main is free this cycle: take the incoming beat directly.
        main_v_d = accept;
        if (accept) begin
          main_d = in_beat;
        end
      end else if (deliver) begin
        // Skid is full here, so in_ready=0 and no accept can collide.
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (!skid_v_q && accept) begin
        // Main is stalled; park the beat in the skid entry.
        skid_d   = in_beat;
        skid_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q      <= '0;
      skid_q      <= '0;
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      main_q      <= main_d;
      skid_q      <= skid_d;
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = main_v_q;
  assign out_rdata = main_q.rdata;
  assign out_alu   = main_q.alu;
  assign out_mux5  = main_q.mux5;
  // Masking WB control on a bubble guarantees no register-file write from it.
  assign out_wb    = (MASK_WB_ON_BUBBLE && !main_v_q) ? '0 : main_q.wb;
  assign stall_cnt = stall_cnt_q;

endmodule
